// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer: in-order reset release of NUM_DOMAINS domains with ready watchdog, retries and loss-of-ready re-sequencing
module reset_release_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_RETRIES    = 1,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                                                   fpga_clk_100,
    input  logic                                                   fpga_reset_n,
    input  logic [NUM_DOMAINS-1:0]                                 domain_ready,
    input  logic                                                   retry,
    output logic [NUM_DOMAINS-1:0]                                 domain_reset_n,
    output logic                                                   all_ready,
    output logic                                                   timeout_err,
    output logic [(NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1)-1:0] err_domain,
    output logic                                                   busy
);
    localparam int IW = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
    localparam int CMAX = HOLD_CYCLES > TIMEOUT_CYCLES ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [1:0] S_HOLD = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2, S_ERR = 2'd3;

    logic [NUM_DOMAINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_DOMAINS-1:0] sync_d [SYNC_STAGES];
    logic [NUM_DOMAINS-1:0] ready_sync;
    logic [1:0]             state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             retries_q, retries_d;
    logic [IW-1:0]          err_domain_q, err_domain_d;
    logic [NUM_DOMAINS-1:0] domain_reset_n_q, domain_reset_n_d;
    logic                   all_ready_q, all_ready_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   busy_q, busy_d;
    logic                   lost;
    logic [IW-1:0]          lo;

    assign ready_sync     = sync_q[SYNC_STAGES-1];
    assign domain_reset_n = domain_reset_n_q;
    assign all_ready      = all_ready_q;
    assign timeout_err    = timeout_err_q;
    assign err_domain     = err_domain_q;
    assign busy           = busy_q;

    always_comb begin
        sync_d[0] = domain_ready;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q + 1'b1;
        retries_d    = retries_q;
        err_domain_d = err_domain_q;
        lost         = 1'b0;
        lo           = '0;
        for (int k = NUM_DOMAINS - 1; k >= 0; k--) begin
            if (!ready_sync[k]) begin
                lost = 1'b1;
                lo   = IW'(k);
            end
        end
        case (state_q)
            S_HOLD: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (ready_sync[idx_q]) begin
                    if (idx_q == IW'(NUM_DOMAINS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_HOLD;
                        idx_d     = idx_q + 1'b1;
                        retries_d = '0;
                        cnt_d     = '0;
                    end
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (retries_q < 4'(MAX_RETRIES)) begin
                        state_d   = S_HOLD;
                        retries_d = retries_q + 1'b1;
                    end else begin
                        state_d      = S_ERR;
                        err_domain_d = idx_q;
                    end
                end
            end
            S_DONE: begin
                cnt_d = '0;
                if (lost) begin
                    state_d      = S_HOLD;
                    idx_d        = lo;
                    retries_d    = '0;
                    err_domain_d = lo;
                end
            end
            default: begin
                cnt_d = '0;
                if (retry) begin
                    state_d   = S_HOLD;
                    retries_d = '0;
                end
            end
        endcase
        for (int k = 0; k < NUM_DOMAINS; k++)
            domain_reset_n_d[k] = state_d == S_DONE || k < int'(idx_d) || (state_d == S_WAIT && k == int'(idx_d));
        all_ready_d   = state_d == S_DONE;
        timeout_err_d = state_d == S_ERR;
        busy_d        = state_d == S_HOLD || state_d == S_WAIT;
    end

    always_ff @(posedge fpga_clk_100) begin
        if (!fpga_reset_n) begin
            sync_q           <= '{default: '0};
            state_q          <= S_HOLD;
            idx_q            <= '0;
            cnt_q            <= '0;
            retries_q        <= '0;
            err_domain_q     <= '0;
            domain_reset_n_q <= '0;
            all_ready_q      <= 1'b0;
            timeout_err_q    <= 1'b0;
            busy_q           <= 1'b1;
        end else begin
            sync_q           <= sync_d;
            state_q          <= state_d;
            idx_q            <= idx_d;
            cnt_q            <= cnt_d;
            retries_q        <= retries_d;
            err_domain_q     <= err_domain_d;
            domain_reset_n_q <= domain_reset_n_d;
            all_ready_q      <= all_ready_d;
            timeout_err_q    <= timeout_err_d;
            busy_q           <= busy_d;
        end
    end
endmodule

// File: doc/reset_release_sequencer.md
# reset_release_sequencer

Parametrised reset-release sequencer and init watchdog for the baseline FPGA fabric. It runs on the 100 MHz fabric clock and releases up to NUM_DOMAINS downstream reset domains one at a time, in index order. Before releasing the next domain it waits for the current domain's ready/init-done flag. Each wait is bounded by a timeout with automatic retries, and the block flags the failing domain. After full bring-up it keeps monitoring the ready flags and re-sequences from the first domain that loses ready.

## Interface
Parameters:
- NUM_DOMAINS, 4: number of reset domains (1..16).
- HOLD_CYCLES, 16: cycles a domain reset is held low before release (>=1).
- TIMEOUT_CYCLES, 1000: maximum cycles in WAIT for one domain (10 us at 100 MHz, >=2).
- MAX_RETRIES, 1: automatic re-attempts per domain after timeout (0..15).
- SYNC_STAGES, 2: synchroniser depth on domain_ready (>=2).

Ports:
- fpga_clk_100  in  1  fabric clock, 100 MHz.
- fpga_reset_n  in  1  reset, synchronous, active-low.
- domain_ready  in  NUM_DOMAINS  per-domain init-done; asynchronous and synchronised internally.
- retry  in  1  single-cycle pulse; honoured only in ERROR.
- domain_reset_n  out  NUM_DOMAINS  per-domain reset, active-low, registered.
- all_ready  out  1  high only in DONE.
- timeout_err  out  1  high only in ERROR.
- err_domain  out  max(1,$clog2(NUM_DOMAINS))  index of the failing domain; holds its last value outside ERROR.
- busy  out  1  high in HOLD or WAIT.

## Operation
- State registers: idx (current domain), cnt, retries.
- Reset (fpga_reset_n=0 at an edge), effective on the next output:
  - domain_reset_n=0, all_ready=0, timeout_err=0, err_domain=0.
  - Synchroniser flops cleared; state=HOLD, idx=0, cnt=0, retries=0.
- HOLD:
  - domain_reset_n[idx]=0 and every higher index =0; every lower index =1.
  - cnt increments each cycle. At cnt==HOLD_CYCLES-1: go to WAIT, cnt=0, domain_reset_n[idx]<=1.
- WAIT:
  - cnt increments each cycle.
  - If ready_sync[idx]=1 and idx<NUM_DOMAINS-1: idx+1, retries=0, cnt=0, go to HOLD.
  - If ready_sync[idx]=1 and idx==NUM_DOMAINS-1: go to DONE.
  - Else if cnt==TIMEOUT_CYCLES-1 and retries<MAX_RETRIES: retries+1, cnt=0, domain_reset_n[idx]<=0, go to HOLD.
  - Else if cnt==TIMEOUT_CYCLES-1: err_domain<=idx, domain_reset_n[idx]<=0, go to ERROR.
  - Ready and timeout on the same edge: ready wins.
- DONE:
  - all_ready=1; domain_reset_n all ones.
  - If any ready_sync[k]=0, with k the lowest such index: idx=k, cnt=0, retries=0, err_domain<=k, go to HOLD.
  - In that case domain_reset_n[k..N-1]<=0 and lower indices stay 1. This is loss-of-ready re-sequencing; no timeout_err.
- ERROR:
  - timeout_err=1; outputs frozen.
  - Only retry=1 or reset leaves ERROR. retry=1: retries=0, cnt=0, go to HOLD with the same idx.
- Deasserting ready on a lower, already released domain during HOLD/WAIT is ignored until DONE.

## Timing
- All outputs are registered; each state's outputs appear the cycle after the transition edge.
- Synchroniser latency is SYNC_STAGES cycles: ready driven before edge E is first seen by the FSM at edge E+SYNC_STAGES.
- Ready delay d: the domain asserts ready d cycles after its domain_reset_n rises.
- Per-domain period P = HOLD_CYCLES + d + SYNC_STAGES + 1 cycles.
- Release of domain 0 occurs HOLD_CYCLES edges after the first edge with fpga_reset_n=1.
- all_ready rises NUM_DOMAINS*P edges after the first edge with fpga_reset_n=1.
- Timeout detection: TIMEOUT_CYCLES cycles after release of the domain.
- Worst-case time to ERROR per domain: (MAX_RETRIES+1)*(HOLD_CYCLES+TIMEOUT_CYCLES) cycles.
- Reset mid-operation, in any state: every output takes its reset value after that edge; in-flight counts are discarded.
- A retry pulse in a non-ERROR state has no effect.

## Test plan
- Nominal, defaults with d=5 on all domains: domain_reset_n steps 0001,0011,0111,1111 at edges 16,40,64,88. all_ready=1 at edge 96; busy=0 after.
- Timeout, MAX_RETRIES=1, domain 2 never ready: domain 2 released twice. ERROR at edge 48+2*(16+1000)=2080 (approx). timeout_err=1, err_domain=2, domain_reset_n=0011.
- Recovery: from the previous ERROR, assert domain_ready[2] and pulse retry. Domain 2 re-held for 16 cycles and released. Sequence completes; all_ready=1, timeout_err=0.
- Loss of ready: in DONE, drop domain_ready[1] for 1 cycle. domain_reset_n=0001 SYNC_STAGES+1 cycles later, all_ready=0, err_domain=1. Re-sequencing reaches DONE again.
- Race: domain_ready[0] first visible via sync on the same edge cnt==TIMEOUT_CYCLES-1. Sequencer advances to domain 1; retries unchanged; no re-hold of domain 0.
- Reset mid-WAIT of domain 3: fpga_reset_n=0 for one edge. Next cycle domain_reset_n=0000, busy=1, and the sequence restarts from domain 0.
